// File: rtl/mux4_rr_arbiter.sv
// Four-way round-robin arbiter driving a shared 4:1 data mux onto one valid/ready port.
// Each grant lasts at most MAX_BURST accepted beats and is followed by one idle cycle.
module mux4_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         gnt,
  output logic [1:0]         sel,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  input  logic               out_ready
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] sel_word;
  logic            xfer;
  logic            found;
  logic [1:0]      idx;
  logic [1:0]      winner;

  always_comb begin
    sel_word = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sel_q == 2'(i)) sel_word = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign out_valid = (|gnt_q) & req[sel_q];
  assign out_data  = out_valid ? sel_word : '0;
  assign xfer      = out_valid & out_ready;
  assign gnt       = gnt_q;
  assign sel       = sel_q;

  // Scan ptr, ptr+1, ... modulo 4; the 2-bit add wraps naturally.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = 4'b0001 << winner;
          sel_d   = winner;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req[sel_q] || (xfer && cnt_q == LAST_BEAT)) begin
          gnt_d   = '0;
          ptr_d   = sel_q + 2'd1;
          state_d = IDLE;
        end else if (xfer) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter (WIDTH=8, MAX_BURST=4): reset, fairness, burst limit,
// backpressure, early drop and asynchronous reset mid-burst.
module tb_mux4_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] in_data;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [7:0]  wd [4];

  int n_assert;
  int n_fail;

  assign in_data = {wd[3], wd[2], wd[1], wd[0]};

  mux4_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in_data   (in_data),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_beat(input string tag, input logic [3:0] g, input logic [1:0] s,
                          input logic [7:0] d);
    chk({tag, "_gnt"}, 32'(gnt), 32'(g));
    chk({tag, "_sel"}, 32'(sel), 32'(s));
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    wd[0] = 8'hA0; wd[1] = 8'hB1; wd[2] = 8'hC2; wd[3] = 8'hD3;
    rst_n     = 1'b0;
    req       = 4'hF;
    out_ready = 1'b1;

    // Reset
    tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // Fairness: grant order 0,1,2,3,0, four beats each, one bubble between
    for (int k = 0; k < 5; k++) begin
      for (int b = 0; b < 4; b++) begin
        chk_beat("fair", 4'b0001 << (k % 4), 2'(k % 4), wd[k % 4]);
        tick();
      end
      chk_bubble("fair_bub");
      if (k == 4) req = 4'b0000;
      tick();
    end
    chk_bubble("idle");

    // Single requester 2, incrementing words; pointer is 1
    req   = 4'b0100;
    wd[2] = 8'h10;
    tick();
    for (int b = 0; b < 4; b++) begin
      chk_beat("single", 4'b0100, 2'd2, 8'h10 + 8'(b));
      wd[2] = wd[2] + 8'd1;
      tick();
    end
    chk_bubble("single_bub");
    chk("single_bub_sel", 32'(sel), 32'd2);
    tick();
    #1;
    chk_beat("single_regrant", 4'b0100, 2'd2, 8'h14);
    req = 4'b0000;
    tick();
    chk_bubble("single_drop");
    tick();

    // Backpressure on requester 1; pointer is 3
    req   = 4'b0010;
    wd[1] = 8'h20;
    tick();
    for (int b = 0; b < 2; b++) begin
      #1;
      chk_beat("bp_pre", 4'b0010, 2'd1, 8'h20 + 8'(b));
      wd[1] = wd[1] + 8'd1;
      tick();
    end
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk_beat("bp_stall", 4'b0010, 2'd1, 8'h22);
      tick();
    end
    out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      #1;
      chk_beat("bp_post", 4'b0010, 2'd1, 8'h22 + 8'(b));
      wd[1] = wd[1] + 8'd1;
      tick();
    end
    chk_bubble("bp_release");
    req = 4'b0000;
    tick();

    // Early drop: pointer is 2, requester 1 granted, then 0 and 3 pending
    req = 4'b0010;
    tick();
    req = 4'b1011;
    for (int b = 0; b < 2; b++) begin
      #1;
      chk_beat("drop_pre", 4'b0010, 2'd1, wd[1]);
      tick();
    end
    req = 4'b1001;
    #1;
    chk("drop_gnt_held", 32'(gnt), 32'b0010);
    chk("drop_valid", 32'(out_valid), 32'd0);
    tick();
    chk_bubble("drop_bub");
    tick();
    chk_beat("drop_next", 4'b1000, 2'd3, wd[3]);
    tick();

    // Asynchronous reset after one transfer of requester 3
    chk_beat("mid_pre", 4'b1000, 2'd3, wd[3]);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sel", 32'(sel), 32'd0);
    req   = 4'b0100;
    rst_n = 1'b1;
    tick();
    for (int b = 0; b < 4; b++) begin
      chk_beat("mid_after", 4'b0100, 2'd2, wd[2]);
      tick();
    end
    chk_bubble("mid_bub");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin controller that shares the 4:1 data mux between four requesters. Each requester raises `req` with its data word. The block grants one requester at a time, drives the mux select, and forwards that requester's words to a single downstream port with a valid/ready handshake. A grant is held for at most `MAX_BURST` accepted beats, then released so the other requesters get a turn.

## Interface
- `WIDTH`, default 8: data word width per requester.
- `MAX_BURST`, default 4: maximum accepted beats per grant. Legal range is 1 or more.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  request per requester; bit i belongs to requester i.
- `in_data`  in  4*WIDTH  requester i's word is on bits `[i*WIDTH +: WIDTH]`.
- `gnt`  out  4  one-hot registered grant; all zero when no grant is held.
- `sel`  out  2  registered mux select; the index of the current or most recent grant.
- `out_valid`  out  1  downstream word is valid.
- `out_data`  out  WIDTH  downstream word.
- `out_ready`  in  1  downstream accepts the word this cycle.

## Operation
- Reset values:
  - state IDLE, `gnt`=0, `sel`=0, beat counter=0.
  - Priority pointer `ptr`=0, so requester 0 has highest priority.
  - `out_valid`=0 and `out_data`=0.
- `out_valid` = (`gnt`≠0) & `req[sel]`.
- `out_data` = `out_valid` ? `in_data` slice at `sel` : 0.
- Transfer: a cycle with `out_valid` & `out_ready`.
- State machine:
  - IDLE, `req`=0: stay in IDLE.
  - IDLE, `req`≠0: choose the first set bit scanning ptr, ptr+1, ... modulo 4. Next edge: `gnt`=onehot(winner), `sel`=winner, beat counter=0, go to GRANT.
  - GRANT, transfer with beat counter = `MAX_BURST`-1: release.
  - GRANT, `req[sel]`=0: release.
  - GRANT, transfer below the limit: increment the beat counter and stay in GRANT.
  - GRANT, `out_valid`=1 but `out_ready`=0: hold everything; no change to beat counter, `gnt` or `sel`.
- Release (next edge):
  - `gnt`=0, state IDLE.
  - `ptr`=(`sel`+1) mod 4, wrapping 3→0.
  - `sel` holds its value.
- Beat counter width is clog2(`MAX_BURST`), minimum 1 bit. With `MAX_BURST`=1 every transfer releases the grant.
- Requester contract:
  - Hold `req` until granted.
  - Keep `in_data` stable while `req` & `gnt` are high and `out_ready` is low.
  - Dropping `req` while granted ends the grant. A word presented but not accepted in that cycle is lost to the arbiter; this is the requester's responsibility.
- There is no timeout. An indefinitely low `out_ready` holds the grant indefinitely.
- An asynchronous reset in any state immediately forces all reset values. An in-flight burst is abandoned.

## Timing
- `req` to `gnt` from IDLE: 1 cycle, registered.
- First `out_valid` appears in the same cycle `gnt` rises.
- Each grant is followed by exactly one IDLE cycle (bubble) before the next grant, even when other requests are pending.
- `out_valid` and `out_data` are combinational from registered `gnt`/`sel` and live `req`/`in_data`. There is no added latency from `in_data` to `out_data`.
- With `out_ready`=1 held and continuous requests, steady-state throughput is `MAX_BURST` beats per `MAX_BURST`+1 cycles.
- `req` changes during GRANT are ignored for arbitration. Only `req[sel]` is observed, for release.

## Test plan
- **Reset:** `rst_n`=0, `req`=4'hF, `out_ready`=1 → `gnt`=0, `sel`=0, `out_valid`=0, `out_data`=0. After `rst_n` deasserts, at the first edge → `gnt`=4'b0001, `sel`=0, `out_data`=`in_data[7:0]`.
- **Single requester, burst limit:** `MAX_BURST`=4, only `req[2]`=1 for 10 cycles, `out_ready`=1, `in_data` word 2 incrementing 0x10, 0x11, … → expect:
  - 4 transfers with `gnt`=4'b0100.
  - 1 cycle with `gnt`=0.
  - Regrant to 4'b0100.
  - No word duplicated or skipped.
- **Fairness:** `req`=4'hF constant, `out_ready`=1 → grant order 0,1,2,3,0. Each grant is 4 transfers, separated by a 1-cycle bubble. After the grant to requester 3, the next grant goes to 0 (wrap).
- **Backpressure:** during a grant to requester 1, after 2 transfers drive `out_ready`=0 for 3 cycles → `gnt`=4'b0010, `out_valid`=1 and `out_data` stay stable. On `out_ready`=1 the remaining 2 beats complete, then release.
- **Early drop:** requester 1 is granted and drops `req[1]` after 2 transfers, with `req`=4'b1001 pending → release, bubble, then `gnt`=4'b1000 (pointer starts at 2; requester 3 wins over 0).
- **Reset mid-burst:** assert `rst_n`=0 asynchronously, between clock edges, after 1 transfer with `MAX_BURST`=4 → `gnt`=0 and `out_valid`=0 immediately, without waiting for a clock edge. After deassert with `req`=4'b0100 → `gnt`=4'b0100 at the first edge, with a full 4-beat budget.
